// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding,
// instruction-word constants and the opcode field position.
// No ports; imported by prog_sequencer.
package seq_pkg;

   localparam int unsigned WORD_W    = 9;
   localparam int unsigned OP_MSB    = 8;
   localparam int unsigned OP_LSB    = 6;
   localparam int unsigned OP_W      = OP_MSB - OP_LSB + 1;

   localparam logic [OP_W-1:0]   MVI_OP    = 3'b001;
   localparam logic [WORD_W-1:0] HALT_WORD = 9'h1FF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_IMM_LATCH,
      ST_ISSUE,
      ST_EXEC,
      ST_HALT
   } seq_state_e;

   // True when the word's opcode field says an immediate word follows.
   function automatic logic is_mvi(input logic [WORD_W-1:0] w);
      return w[OP_MSB:OP_LSB] == MVI_OP;
   endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Instruction-stream bus between the sequencer, the instruction ROM and the
// processor control unit.
//   rom_addr_o : ROM address (sequencer -> ROM)
//   rom_data_i : ROM read data, one cycle after the address
//   din_o      : word presented on processor Din
//   run_o      : one-cycle instruction issue pulse
//   done_i     : processor Done
// master = sequencer side, slave = ROM/processor side.
interface prog_sequencer_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 9
);

   logic [ADDR_W-1:0] rom_addr_o;
   logic [DATA_W-1:0] rom_data_i;
   logic [DATA_W-1:0] din_o;
   logic              run_o;
   logic              done_i;

   modport master (
      output rom_addr_o,
      output din_o,
      output run_o,
      input  rom_data_i,
      input  done_i
   );

   modport slave (
      input  rom_addr_o,
      input  din_o,
      input  run_o,
      output rom_data_i,
      output done_i
   );

endinterface

// File: rtl/seq_watchdog.sv
// EXEC-phase watchdog: counts cycles spent waiting for Done and flags a
// timeout in the cycle that would otherwise be the TIMEOUT_CYC-th wait
// without Done.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : restart the count (asserted while issuing)
//   count_en_i : count this cycle (asserted while executing)
//   done_i     : processor Done; suppresses the timeout in its cycle
//   timeout_c  : combinational timeout flag
module seq_watchdog #(
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic count_en_i,
   input  logic done_i,
   output logic timeout_c
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   // Saturating wait counter.
   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         cnt <= '0;
      end else if (count_en_i && (cnt != CW'(TIMEOUT_CYC))) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign timeout_c = count_en_i && !done_i && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: fetches instruction words (plus the immediate word of
// an mvi) from the synchronous instruction ROM, issues them to the processor
// with a one-cycle run pulse, waits for Done and advances the PC. Stops on
// the HALT word or on a stop request.
// Optional feature: define SEQ_TIMEOUT_EN to add an EXEC watchdog and the
// err_o output.
// Ports:
//   clk, rst     : processor clock, synchronous active-high reset
//   start_i      : begin at address 0 (only from IDLE or HALT)
//   stop_i       : finish the current instruction then go idle
//   bus          : ROM address/data, Din, run, Done (master modport)
//   busy_o       : not in IDLE or HALT
//   halted_o     : in HALT
//   pc_o         : current PC
//   instr_cnt_o  : retired instructions, saturating at 255
//   err_o        : sticky EXEC timeout (SEQ_TIMEOUT_EN only)
module prog_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = WORD_W
`ifdef SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 15
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                stop_i,
   prog_sequencer_if.master    bus,
   output logic                busy_o,
   output logic                halted_o,
   output logic [ADDR_W-1:0]   pc_o,
   output logic [7:0]          instr_cnt_o
`ifdef SEQ_TIMEOUT_EN
   ,
   output logic                err_o
`endif
);

   localparam int unsigned CNT_W = 8;

   seq_state_e        state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] imm;
   logic              stop_pend;
   logic [CNT_W-1:0]  instr_cnt;
   logic [DATA_W-1:0] din_q;
   logic              run_q;
   logic              busy_q;
   logic              halted_q;
   logic [ADDR_W-1:0] rom_addr_c;
   logic              in_flight_c;
   logic              timeout_c;

   assign in_flight_c = (state != ST_IDLE) && (state != ST_HALT);

`ifdef SEQ_TIMEOUT_EN
   logic err_q;

   seq_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (state == ST_ISSUE),
      .count_en_i (state == ST_EXEC),
      .done_i     (bus.done_i),
      .timeout_c  (timeout_c)
   );

   assign err_o = err_q;
`else
   assign timeout_c = 1'b0;
`endif

   // ROM address: PC, except in DECODE of an mvi where the immediate word is
   // requested so it arrives in IMM_LATCH.
   always_comb begin
      rom_addr_c = pc;
      if ((state == ST_DECODE) && is_mvi(bus.rom_data_i)) begin
         rom_addr_c = pc + ADDR_W'(1);
      end
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pc        <= '0;
         ir        <= '0;
         imm       <= '0;
         stop_pend <= 1'b0;
         instr_cnt <= '0;
         din_q     <= '0;
         run_q     <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         run_q <= 1'b0;
         if (stop_i && in_flight_c) begin
            stop_pend <= 1'b1;
         end

         case (state)
            ST_IDLE, ST_HALT: begin
               if (start_i) begin
                  state     <= ST_FETCH;
                  pc        <= '0;
                  instr_cnt <= '0;
                  stop_pend <= 1'b0;
                  busy_q    <= 1'b1;
                  halted_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
               end
            end

            ST_FETCH: begin
               state <= ST_DECODE;
            end

            ST_DECODE: begin
               ir <= bus.rom_data_i;
               if (bus.rom_data_i == DATA_W'(HALT_WORD)) begin
                  // A pending stop is satisfied by halting.
                  state     <= ST_HALT;
                  stop_pend <= 1'b0;
                  busy_q    <= 1'b0;
                  halted_q  <= 1'b1;
               end else if (is_mvi(bus.rom_data_i)) begin
                  state <= ST_IMM_LATCH;
               end else begin
                  state <= ST_ISSUE;
                  din_q <= bus.rom_data_i;
                  run_q <= 1'b1;
               end
            end

            ST_IMM_LATCH: begin
               imm   <= bus.rom_data_i;
               state <= ST_ISSUE;
               din_q <= ir;
               run_q <= 1'b1;
            end

            ST_ISSUE: begin
               // The processor sees the immediate on Din while it executes mvi.
               state <= ST_EXEC;
               din_q <= is_mvi(ir) ? imm : ir;
            end

            ST_EXEC: begin
               if (timeout_c) begin
                  state     <= ST_HALT;
                  stop_pend <= 1'b0;
                  busy_q    <= 1'b0;
                  halted_q  <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                  err_q     <= 1'b1;
`endif
               end else if (bus.done_i) begin
                  pc <= pc + (is_mvi(ir) ? ADDR_W'(2) : ADDR_W'(1));
                  if (instr_cnt != {CNT_W{1'b1}}) begin
                     instr_cnt <= instr_cnt + CNT_W'(1);
                  end
                  if (stop_pend || stop_i) begin
                     state     <= ST_IDLE;
                     stop_pend <= 1'b0;
                     busy_q    <= 1'b0;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end

            default: begin
               state    <= ST_IDLE;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rom_addr_o = rom_addr_c;
   assign bus.din_o      = din_q;
   assign bus.run_o      = run_q;
   assign busy_o         = busy_q;
   assign halted_o       = halted_q;
   assign pc_o           = pc;
   assign instr_cnt_o    = instr_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: cycle tables for the basic and mvi
// programs (including reset mid-EXEC), then hand-written sequences for
// address wrap, stop/ignored start, counter saturation and, when built with
// SEQ_TIMEOUT_EN, the EXEC timeout.
module tb_prog_sequencer;

   typedef struct packed {
      logic       start;
      logic       stop;
      logic       done;
      logic       rst;
      logic       run;
      logic [8:0] din;
      logic       busy;
      logic       halted;
      logic [4:0] pc;
      logic [7:0] cnt;
      logic [4:0] addr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       done_man = 1'b0;
   logic       done_auto = 1'b0;
   logic       auto_en = 1'b0;
   int         auto_dly = 1;
   logic       busy;
   logic       halted;
   logic [4:0] pc;
   logic [7:0] cnt;
   logic [8:0] rom [32];
   logic [8:0] rom_q = 9'h000;
`ifdef SEQ_TIMEOUT_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;

   vec_t t1[$];
   vec_t t2[$];

   prog_sequencer_if #(.ADDR_W(5), .DATA_W(9)) bus ();

   prog_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .stop_i      (stop),
      .bus         (bus),
      .busy_o      (busy),
      .halted_o    (halted),
      .pc_o        (pc),
      .instr_cnt_o (cnt)
`ifdef SEQ_TIMEOUT_EN
      ,
      .err_o       (err)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction ROM.
   always @(posedge clk) rom_q <= rom[bus.rom_addr_o];
   assign bus.rom_data_i = rom_q;
   assign bus.done_i     = done_man | done_auto;

   // Processor stand-in: Done in the auto_dly-th EXEC cycle after each run.
   initial begin
      forever begin
         @(negedge clk);
         if (auto_en && bus.run_o) begin
            repeat (auto_dly) @(negedge clk);
            done_auto = 1'b1;
            @(negedge clk);
            done_auto = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   function automatic vec_t mk(input logic st, input logic sp, input logic dn, input logic rs,
                               input logic rn, input logic [8:0] di, input logic bz,
                               input logic hl, input logic [4:0] p, input logic [7:0] c,
                               input logic [4:0] a);
      vec_t v;
      v.start = st; v.stop = sp; v.done = dn; v.rst = rs;
      v.run = rn; v.din = di; v.busy = bz; v.halted = hl;
      v.pc = p; v.cnt = c; v.addr = a;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // mode 0: pc==val, 1: busy low, 2: run high, 3: cnt==val
   task automatic wait_for(input int mode, input logic [7:0] val, input int budget,
                           input string nm);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         case (mode)
            0:       hit = (pc == val[4:0]);
            1:       hit = !busy;
            2:       hit = bus.run_o;
            default: hit = (cnt == val);
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s: no event within %0d cycles", nm, budget);
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      @(negedge clk);
      start    = v.start;
      stop     = v.stop;
      done_man = v.done;
      rst      = v.rst;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].run", tag, idx),    32'(bus.run_o),      32'(v.run));
      chk($sformatf("%s[%0d].din", tag, idx),    32'(bus.din_o),      32'(v.din));
      chk($sformatf("%s[%0d].busy", tag, idx),   32'(busy),           32'(v.busy));
      chk($sformatf("%s[%0d].halted", tag, idx), 32'(halted),         32'(v.halted));
      chk($sformatf("%s[%0d].pc", tag, idx),     32'(pc),             32'(v.pc));
      chk($sformatf("%s[%0d].cnt", tag, idx),    32'(cnt),            32'(v.cnt));
      chk($sformatf("%s[%0d].addr", tag, idx),   32'(bus.rom_addr_o), 32'(v.addr));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; stop = 1'b0; done_man = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic fill_rom(input logic [8:0] w);
      for (int i = 0; i < 32; i++) rom[i] = w;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop_now();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   initial begin
      // mv R0,R1 then HALT; done held through ISSUE (ignored); restart; rst in EXEC.
      t1.push_back(mk(1,0,0,0, 0,9'h000,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,0,0, 0,9'h000,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,0,0, 1,9'h001,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,1,0, 0,9'h001,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,0,0, 0,9'h001,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,1,0, 0,9'h001,1,0,5'd1,8'd1,5'd1));
      t1.push_back(mk(0,0,0,0, 0,9'h001,1,0,5'd1,8'd1,5'd1));
      t1.push_back(mk(0,0,0,0, 0,9'h001,0,1,5'd1,8'd1,5'd1));
      t1.push_back(mk(0,1,0,0, 0,9'h001,0,1,5'd1,8'd1,5'd1));
      t1.push_back(mk(1,0,0,0, 0,9'h001,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,0,0, 0,9'h001,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,0,0, 1,9'h001,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,0,0, 0,9'h001,1,0,5'd0,8'd0,5'd0));
      t1.push_back(mk(0,0,0,1, 0,9'h000,0,0,5'd0,8'd0,5'd0));
      // mvi R2,#0AB then HALT.
      t2.push_back(mk(1,0,0,0, 0,9'h000,1,0,5'd0,8'd0,5'd0));
      t2.push_back(mk(0,0,0,0, 0,9'h000,1,0,5'd0,8'd0,5'd1));
      t2.push_back(mk(0,0,0,0, 0,9'h000,1,0,5'd0,8'd0,5'd0));
      t2.push_back(mk(0,0,0,0, 1,9'h050,1,0,5'd0,8'd0,5'd0));
      t2.push_back(mk(0,0,0,0, 0,9'h0AB,1,0,5'd0,8'd0,5'd0));
      t2.push_back(mk(0,0,0,0, 0,9'h0AB,1,0,5'd0,8'd0,5'd0));
      t2.push_back(mk(0,0,1,0, 0,9'h0AB,1,0,5'd2,8'd1,5'd2));
      t2.push_back(mk(0,0,0,0, 0,9'h0AB,1,0,5'd2,8'd1,5'd2));
      t2.push_back(mk(0,0,0,0, 0,9'h0AB,0,1,5'd2,8'd1,5'd2));

      // Reset state.
      fill_rom(9'h001);
      rom[1] = 9'h1FF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.run",    32'(bus.run_o),      32'd0);
      chk("reset.din",    32'(bus.din_o),      32'd0);
      chk("reset.busy",   32'(busy),           32'd0);
      chk("reset.halted", 32'(halted),         32'd0);
      chk("reset.pc",     32'(pc),             32'd0);
      chk("reset.cnt",    32'(cnt),            32'd0);
      chk("reset.addr",   32'(bus.rom_addr_o), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < t1.size(); i++) apply(t1[i], "basic", i);

      fill_rom(9'h001);
      rom[0] = 9'h050;
      rom[1] = 9'h0AB;
      rom[2] = 9'h1FF;
      do_reset();
      for (int i = 0; i < t2.size(); i++) apply(t2[i], "mvi", i);

      // mvi at 31 with its immediate at address 0: PC wraps to 1.
      fill_rom(9'h001);
      rom[0]  = 9'h0C5;
      rom[31] = 9'h050;
      do_reset();
      auto_en  = 1'b1;
      auto_dly = 1;
      pulse_start();
      wait_for(0, 8'd31, 300, "wrap.reach_pc31");
      @(negedge clk);
      chk("wrap.decode_addr", 32'(bus.rom_addr_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("wrap.issue_run", 32'(bus.run_o), 32'd1);
      chk("wrap.issue_din", 32'(bus.din_o), 32'h050);
      @(negedge clk);
      chk("wrap.exec_din", 32'(bus.din_o), 32'h0C5);
      @(negedge clk);
      chk("wrap.pc", 32'(pc), 32'd1);
      chk("wrap.cnt", 32'(cnt), 32'd32);
      pulse_stop_now();
      wait_for(1, 8'd0, 20, "wrap.idle");
      chk("wrap.stop_pc", 32'(pc), 32'd2);
      chk("wrap.stop_cnt", 32'(cnt), 32'd33);

      // Stop during FETCH of the 3rd instruction, slow Done, start while busy.
      fill_rom(9'h001);
      rom[3] = 9'h1FF;
      do_reset();
      auto_dly = 4;
      pulse_start();
      wait_for(0, 8'd2, 100, "stop.reach_pc2");
      pulse_stop_now();
      wait_for(2, 8'd0, 10, "stop.run3");
      chk("stop.din3", 32'(bus.din_o), 32'h001);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for(1, 8'd0, 20, "stop.idle");
      chk("stop.cnt", 32'(cnt), 32'd3);
      chk("stop.pc", 32'(pc), 32'd3);
      chk("stop.halted", 32'(halted), 32'd0);
      @(negedge clk);
      chk("stop.stays_idle", 32'(busy), 32'd0);

      // Endless loop: retired count saturates at 255.
      fill_rom(9'h001);
      do_reset();
      auto_dly = 1;
      pulse_start();
      wait_for(3, 8'd255, 1500, "sat.reach_255");
      repeat (250) @(negedge clk);
      chk("sat.cnt_held", 32'(cnt), 32'd255);
      chk("sat.still_busy", 32'(busy), 32'd1);
      pulse_stop_now();
      wait_for(1, 8'd0, 20, "sat.idle");
      chk("sat.cnt_idle", 32'(cnt), 32'd255);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("sat.restart_cnt", 32'(cnt), 32'd0);
      chk("sat.restart_busy", 32'(busy), 32'd1);
      auto_en = 1'b0;

`ifdef SEQ_TIMEOUT_EN
      // No Done: timeout after 15 EXEC cycles, start clears the error.
      fill_rom(9'h001);
      do_reset();
      pulse_start();
      wait_for(2, 8'd0, 10, "tmo.run");
      repeat (15) @(negedge clk);
      chk("tmo.err_before", 32'(err), 32'd0);
      chk("tmo.busy_before", 32'(busy), 32'd1);
      @(negedge clk);
      chk("tmo.err", 32'(err), 32'd1);
      chk("tmo.halted", 32'(halted), 32'd1);
      chk("tmo.pc", 32'(pc), 32'd0);
      pulse_start();
      chk("tmo.err_cleared", 32'(err), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
